// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction memory request/acknowledge port.
//   imem_req   : fetch request (core -> memory)
//   imem_addr  : byte address of the requested word (core -> memory)
//   imem_ack   : imem_rdata valid this cycle (memory -> core)
//   imem_rdata : fetched instruction word (memory -> core)
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch/execute sequencer with single-step, branch/jump PC update and fetch timeout.
//   clk, reset                   : clock, synchronous active-high reset
//   imem                         : instruction memory port (master side)
//   step_en, step                : single-step mode select, debounced step button level
//   Branch, Bne, Jump, zero      : decoder/ALU controls, consumed only at commit
//   instruction, instr_valid     : registered instruction word, executing flag
//   pc, pc_plus4                 : current instruction address and its successor
//   retired, instr_count, fault  : commit pulse, retire counter, sticky fetch-timeout flag
module instruction_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        imem,
    input  logic                       step_en,
    input  logic                       step,
    input  logic                       Branch,
    input  logic                       Bne,
    input  logic                       Jump,
    input  logic                       zero,
    output logic [31:0]                instruction,
    output logic                       instr_valid,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    output logic                       retired,
    output logic [15:0]                instr_count,
    output logic                       fault
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {FETCH, EXEC, FAULT} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          step_q;
    logic          taken;
    logic          commit;
    logic [31:0]   br_off;
    logic [31:0]   next_pc;

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;
    assign taken          = Branch & (zero ^ Bne);
    assign br_off         = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign next_pc        = Jump  ? {pc_plus4[31:28], instruction[25:0], 2'b00} :
                            taken ? pc_plus4 + br_off : pc_plus4;
    // step_en is re-evaluated every EXEC cycle, so dropping it releases a held step
    assign commit         = (state == EXEC) && (!step_en || (step && !step_q));

    // retired is registered: it pulses in the cycle after the commit edge,
    // together with the updated pc and instr_count
    always_ff @(posedge clk) begin
        step_q  <= step;
        retired <= 1'b0;
        if (reset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            instruction   <= 32'hFC00_0000;
            instr_count   <= 16'd0;
            wait_cnt      <= '0;
            step_q        <= 1'b0;
            imem.imem_req <= 1'b1;
            instr_valid   <= 1'b0;
            fault         <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instruction   <= imem.imem_rdata;
                        state         <= EXEC;
                        imem.imem_req <= 1'b0;
                        instr_valid   <= 1'b1;
                    end else if (wait_cnt == CW'(TIMEOUT_CYCLES)) begin
                        state         <= FAULT;
                        imem.imem_req <= 1'b0;
                        fault         <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                EXEC: begin
                    if (commit) begin
                        retired       <= 1'b1;
                        instr_count   <= instr_count + 16'd1;
                        pc            <= next_pc;
                        wait_cnt      <= '0;
                        state         <= FETCH;
                        imem.imem_req <= 1'b1;
                        instr_valid   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
